pwr_rail_seq: RTL
=================

Name: pwr_rail_seq

Overview:
- Parametrised N-rail power sequencer.
- Brings rails up in ascending index order: each rail is enabled, its power-good is awaited with a timeout, then an inter-rail delay runs before the next rail.
- Takes rails down in descending order with fixed delays. Detects timeout and power-good dropout faults and performs an emergency shutdown.
- Sits under the platform power-control block; replaces per-rail hand-coded enable/pwrgd chains. Timing is counted in 1 ms ticks from the shared tick generator.

Parameters:
- NUM_RAILS, 4, number of sequenced rails (1..16).
- TMO_TICKS, 100, max 1 ms ticks allowed from rail enable to its pwrgd (1..255).
- DLY_TICKS, 2, 1 ms ticks between consecutive rail steps, up and down (0..255).
- IDX_W, max(1,$clog2(NUM_RAILS)), rail index width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cnt1ms_done  in  1  single-cycle 1 ms tick strobe
- pwr_req  in  1  level request: 1 = power up and hold, 0 = power down
- rail_pwrgd  in  NUM_RAILS  per-rail power-good, already synchronised
- rail_en  out  NUM_RAILS  per-rail enable, registered
- all_pwrok  out  1  all rails up and good
- seq_busy  out  1  up or down sequence in progress
- seq_fault  out  1  sequencer latched a fault
- fault_rail  out  IDX_W  index of the faulting rail
- fault_drop  out  1  fault type: 0 = enable timeout, 1 = pwrgd dropout

Behaviour:
- Reset (async assert, sync release): state IDLE, idx=0, timer=0. All outputs 0.
- Timer: IDX-independent 8-bit counter, cleared on every state entry. Increments on each cnt1ms_done while in UP_WAIT, UP_DLY or DN_DLY. Saturates, no wrap.
- IDLE: rail_en=0. pwr_req=1 -> UP_WAIT with idx=0; rail_en[0]=1 on the next cycle.
- UP_WAIT:
  - rail_en = bits 0..idx set.
  - If rail_pwrgd[idx]=1 -> UP_DLY.
  - Else if timer==TMO_TICKS -> FAULT, fault_drop=0.
  - pwrgd wins over a same-cycle timeout.
- UP_DLY: when timer==DLY_TICKS (immediately if DLY_TICKS=0):
  - idx<NUM_RAILS-1 -> idx+1, UP_WAIT.
  - else -> ON.
  - DLY_TICKS=0: rail_en[idx+1] rises 2 clk after rail_pwrgd[idx] is first sampled high.
- ON: all_pwrok=1, registered, asserted the cycle after entering ON. seq_busy=0.
- Dropout check (UP_WAIT, UP_DLY, ON):
  - Any rail j with confirmed pwrgd (j<idx, or j==idx in UP_DLY/ON) sampled low -> FAULT, fault_drop=1, fault_rail=lowest such j.
  - Dropout takes priority over timeout, pwr_req deassertion and step advance in the same cycle.
- pwr_req=0 in UP_WAIT, UP_DLY or ON:
  - all_pwrok=0 next cycle.
  - Go to DN_DLY after deasserting rail_en[idx]; idx keeps the highest enabled rail.
- DN_DLY: when timer==DLY_TICKS:
  - idx>0 -> clear rail_en[idx-1], idx-1, re-enter DN_DLY.
  - idx==0 -> IDLE.
  - Down sequence ignores rail_pwrgd (no fault checks) and ignores pwr_req re-assertion. A pending pwr_req=1 starts a fresh up sequence from IDLE one cycle later.
- FAULT:
  - rail_en=0 next cycle, all rails together, no ordered shutdown.
  - all_pwrok=0. seq_fault=1. fault_rail/fault_drop frozen.
  - Exit to IDLE only when pwr_req=0. seq_fault, fault_rail and fault_drop clear on the IDLE entry cycle.
- seq_busy=1 in UP_WAIT, UP_DLY, DN_DLY; 0 otherwise.
- Asynchronous reset mid-sequence drops all rail_en immediately, with no ordered shutdown.
- NUM_RAILS=1: UP_DLY goes straight to ON after the delay; DN_DLY exits to IDLE after one delay.

Test Plan:
- Nominal up/down (N=4, TMO=10, DLY=2):
  - Raise pwr_req; each rail_pwrgd returns 3 ticks after its enable.
  - rail_en steps 0001->0011->0111->1111, each 2 ticks after the prior pwrgd; all_pwrok=1 after rail 3 delay.
  - Drop pwr_req -> 1111->0111->0011->0001->0000 at 2-tick spacing; seq_busy=0 at end.
- Timeout: hold rail_pwrgd[2]=0 -> FAULT after 10 ticks from rail_en[2].
  - rail_en=0 next cycle; seq_fault=1, fault_rail=2, fault_drop=0.
  - Deassert pwr_req -> seq_fault clears.
- Dropout: in ON, pull rail_pwrgd[1] low for 1 cycle -> FAULT, fault_rail=1, fault_drop=1, all_pwrok=0, rail_en=0 next cycle.
- Abort mid-up: deassert pwr_req in UP_WAIT of rail 2 -> rail_en 0111->0011 immediately, then ordered down to 0000. Reassert pwr_req during DN_DLY -> fresh up sequence starts only after IDLE.
- Same-cycle priority:
  - rail_pwrgd[idx] rises on the cycle timer==TMO -> no fault, sequence advances.
  - Dropout coincident with pwr_req=0 -> FAULT.
- Reset mid-operation: assert rst_n=0 while in ON -> all outputs 0 asynchronously. After release, IDLE; with pwr_req=1, rail_en[0]=1 on the 2nd clock after release.

Source files
------------

// File: rtl/pwr_rail_seq.sv
// N-rail power sequencer: ordered bring-up with pwrgd timeout, ordered
// take-down, and emergency shutdown on timeout or pwrgd dropout.
module pwr_rail_seq #(
  parameter int NUM_RAILS = 4,
  parameter int TMO_TICKS = 100,
  parameter int DLY_TICKS = 2,
  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt1ms_done,
  input  logic                 pwr_req,
  input  logic [NUM_RAILS-1:0] rail_pwrgd,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_pwrok,
  output logic                 seq_busy,
  output logic                 seq_fault,
  output logic [IDX_W-1:0]     fault_rail,
  output logic                 fault_drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_UP_WAIT, S_UP_DLY, S_ON, S_DN_DLY, S_FAULT
  } state_t;

  localparam logic [7:0]       TMO_T    = 8'(TMO_TICKS);
  localparam logic [7:0]       DLY_T    = 8'(DLY_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             timer_q, timer_d;
  logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
  logic                   all_pwrok_q, all_pwrok_d;
  logic                   seq_fault_q, seq_fault_d;
  logic [IDX_W-1:0]       fault_rail_q, fault_rail_d;
  logic                   fault_drop_q, fault_drop_d;
  logic                   rel_q;
  logic                   enter;
  logic                   drop_hit;
  logic [IDX_W-1:0]       drop_idx;
  logic                   flt_load;
  logic                   flt_drop;
  logic [IDX_W-1:0]       flt_rail;

  // Reset release is retimed by one clock; the FSM holds its reset state until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q        <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      rail_en_q    <= '0;
      all_pwrok_q  <= 1'b0;
      seq_fault_q  <= 1'b0;
      fault_rail_q <= '0;
      fault_drop_q <= 1'b0;
    end else begin
      rel_q <= 1'b1;
      if (rel_q) begin
        state_q      <= state_d;
        idx_q        <= idx_d;
        timer_q      <= timer_d;
        rail_en_q    <= rail_en_d;
        all_pwrok_q  <= all_pwrok_d;
        seq_fault_q  <= seq_fault_d;
        fault_rail_q <= fault_rail_d;
        fault_drop_q <= fault_drop_d;
      end
    end
  end

  always_comb begin
    drop_hit = 1'b0;
    drop_idx = '0;
    // Scan high to low so the lowest dropped confirmed rail is reported.
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (!rail_pwrgd[j] &&
          ((state_q == S_UP_WAIT && j < int'(idx_q)) ||
           ((state_q == S_UP_DLY || state_q == S_ON) && j <= int'(idx_q)))) begin
        drop_hit = 1'b1;
        drop_idx = IDX_W'(j);
      end
    end

    state_d  = state_q;
    idx_d    = idx_q;
    enter    = 1'b0;
    flt_load = 1'b0;
    flt_drop = 1'b0;
    flt_rail = idx_q;
    case (state_q)
      S_IDLE: begin
        if (pwr_req) begin
          state_d = S_UP_WAIT;
          idx_d   = '0;
          enter   = 1'b1;
        end
      end
      S_UP_WAIT, S_UP_DLY, S_ON: begin
        if (drop_hit) begin
          state_d  = S_FAULT;
          enter    = 1'b1;
          flt_load = 1'b1;
          flt_drop = 1'b1;
          flt_rail = drop_idx;
        end else if (!pwr_req) begin
          state_d = S_DN_DLY;
          enter   = 1'b1;
        end else if (state_q == S_UP_WAIT) begin
          if (rail_pwrgd[idx_q]) begin
            state_d = S_UP_DLY;
            enter   = 1'b1;
          end else if (timer_q == TMO_T) begin
            state_d  = S_FAULT;
            enter    = 1'b1;
            flt_load = 1'b1;
          end
        end else if (state_q == S_UP_DLY && timer_q == DLY_T) begin
          enter = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_ON;
          end else begin
            state_d = S_UP_WAIT;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      S_DN_DLY: begin
        if (timer_q == DLY_T) begin
          enter = 1'b1;
          if (idx_q == '0) state_d = S_IDLE;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      S_FAULT: begin
        if (!pwr_req) begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (enter) begin
      timer_d = '0;
    end else if ((state_q == S_UP_WAIT || state_q == S_UP_DLY || state_q == S_DN_DLY) &&
                 cnt1ms_done && timer_q != 8'hFF) begin
      timer_d = timer_q + 8'd1;
    end

    // Down sequence holds only the rails strictly below idx.
    rail_en_d = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if ((state_d == S_UP_WAIT || state_d == S_UP_DLY || state_d == S_ON) && j <= int'(idx_d))
        rail_en_d[j] = 1'b1;
      if (state_d == S_DN_DLY && j < int'(idx_d))
        rail_en_d[j] = 1'b1;
    end

    all_pwrok_d  = (state_d == S_ON);
    seq_fault_d  = (state_d == S_FAULT);
    fault_rail_d = fault_rail_q;
    fault_drop_d = fault_drop_q;
    if (flt_load) begin
      fault_rail_d = flt_rail;
      fault_drop_d = flt_drop;
    end else if (state_d == S_IDLE) begin
      fault_rail_d = '0;
      fault_drop_d = 1'b0;
    end
  end

  assign rail_en    = rail_en_q;
  assign all_pwrok  = all_pwrok_q;
  assign seq_busy   = (state_q == S_UP_WAIT) || (state_q == S_UP_DLY) || (state_q == S_DN_DLY);
  assign seq_fault  = seq_fault_q;
  assign fault_rail = fault_rail_q;
  assign fault_drop = fault_drop_q;

endmodule
